// File: rtl/lut_frac_pkg.sv
// rtl/lut_frac_pkg.sv - shared types and helpers for the fracturable LUT
package lut_frac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    // Width of the mode field: enough bits to hold 0..frac_levels, never below one bit.
    function automatic int calc_mode_w(input int frac_levels);
        int w;
        w = $clog2(frac_levels + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // A mode selects 2^mode sub-LUTs; anything beyond the supported depth is rejected.
    function automatic logic mode_legal(input int unsigned mode, input int unsigned frac_levels);
        return (mode <= frac_levels);
    endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serial config shadow register, load FSM and commit status
module lut_cfg_loader
    import lut_frac_pkg::*;
#(
    parameter int FRAC_LEVELS = 1,
    parameter int MEM_SIZE    = 16,
    parameter int MODE_W      = 1,
    parameter int CFG_W       = MEM_SIZE + MODE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             cfg_in,
    output logic [CFG_W-1:0] shadow,
    output logic             commit,
    output logic             in_commit,
    output logic             cfg_out,
    output logic             cfg_done,
    output logic             cfg_valid,
    output logic             cfg_err
);

    localparam int CNT_W = $clog2(CFG_W + 1);

    cfg_state_e       state_q, state_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             legal;

    // The commit decision always looks at the shadow as it stood before this edge.
    assign legal = mode_legal(32'(shadow_q[CFG_W-1 -: MODE_W]), FRAC_LEVELS);

    // Next-state logic: shifting is independent of state, the FSM only tracks word boundaries.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        err_d    = err_q;
        if (cen) begin
            shadow_d = {shadow_q[CFG_W-2:0], cfg_in};
        end
        case (state_q)
            ST_IDLE: begin
                if (cen) begin
                    count_d = CNT_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cen) begin
                    if (count_q == CNT_W'(CFG_W - 1)) begin
                        count_d = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                done_d = 1'b1;
                if (legal) begin
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                // A shift in the commit cycle starts the next word straight away.
                if (cen) begin
                    count_d = CNT_W'(1);
                    state_d = ST_LOAD;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign shadow    = shadow_q;
    assign commit    = (state_q == ST_COMMIT) && legal;
    assign in_commit = (state_q == ST_COMMIT);
    assign cfg_out   = shadow_q[CFG_W-1];
    assign cfg_done  = done_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: rtl/lut_frac_cfg.sv
// rtl/lut_frac_cfg.sv - fracturable LUT with serial atomic configuration and user write port
module lut_frac_cfg
    import lut_frac_pkg::*;
#(
    parameter int  INPUTS      = 4,
    parameter int  FRAC_LEVELS = 1,
    localparam int MEM_SIZE    = 2 ** INPUTS,
    localparam int NOUT        = 2 ** FRAC_LEVELS,
    localparam int MODE_W      = calc_mode_w(FRAC_LEVELS),
    localparam int CFG_W       = MEM_SIZE + MODE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NOUT*INPUTS-1:0] addr,
    output logic [NOUT-1:0]        out,
    input  logic                   cen,
    input  logic                   cfg_in,
    output logic                   cfg_out,
    output logic                   cfg_done,
    output logic                   cfg_valid,
    output logic                   cfg_err,
    input  logic                   write_en,
    input  logic [INPUTS-1:0]      write_addr,
    input  logic                   data_in
);

    logic [CFG_W-1:0]    shadow;
    logic                commit;
    logic                in_commit;
    logic [MEM_SIZE-1:0] mem_q, mem_d;
    logic [MODE_W-1:0]   mode_q, mode_d;

    lut_cfg_loader #(
        .FRAC_LEVELS (FRAC_LEVELS),
        .MEM_SIZE    (MEM_SIZE),
        .MODE_W      (MODE_W),
        .CFG_W       (CFG_W)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .cfg_in    (cfg_in),
        .shadow    (shadow),
        .commit    (commit),
        .in_commit (in_commit),
        .cfg_out   (cfg_out),
        .cfg_done  (cfg_done),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err)
    );

    // Active table update: a commit replaces everything, otherwise a user write touches one bit.
    always_comb begin
        mem_d  = mem_q;
        mode_d = mode_q;
        if (commit) begin
            mem_d  = shadow[MEM_SIZE-1:0];
            mode_d = shadow[CFG_W-1 -: MODE_W];
        end else if (write_en && cfg_valid && !in_commit) begin
            mem_d[write_addr] = data_in;
        end
    end

    // Active table and mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            mode_q <= '0;
        end else begin
            mem_q  <= mem_d;
            mode_q <= mode_d;
        end
    end

    int                m;
    int                k;
    logic [INPUTS-1:0] mask;
    logic [INPUTS-1:0] sub_addr;
    logic [INPUTS-1:0] idx;

    // Fracture read mux: sub-LUT j owns the j-th 2^K slice and uses the low K bits of its address.
    always_comb begin
        out      = '0;
        m        = 32'(mode_q);
        k        = INPUTS - m;
        mask     = INPUTS'((1 << k) - 1);
        sub_addr = '0;
        idx      = '0;
        if (cfg_valid) begin
            for (int j = 0; j < NOUT; j++) begin
                if (j < (1 << m)) begin
                    sub_addr = addr[j*INPUTS +: INPUTS] & mask;
                    idx      = INPUTS'(j << k) | sub_addr;
                    out[j]   = mem_q[idx];
                end
            end
        end
    end

endmodule
